// File: rtl/wb_block_master.sv
// Wishbone block initiator: moves count_i 32-bit words between a local stream and a slave, one classic cycle per word.
// Optional ack timeout abort is compiled in with `define WB_TIMEOUT_EN.
module wb_block_master #(
  parameter int CNT_W = 16
`ifdef WB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_addr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_data_o,
  input  logic [31:0]      wb_data_i,
  input  logic             wb_ack_i,
  output logic [2:0]       dbg_state_o
);

  // Local stream handshake: a write word moves on a cycle where wr_valid_i and wr_ready_o are both high.
  // rd_valid_o is a single-cycle pulse with no backpressure.
  typedef enum logic [2:0] {IDLE, FETCH, REQ, GAP, DONE} state_t;

  state_t           state, next_state;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] rem_q;
  logic             dir_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;
  logic             limit_hit;
  logic             req;

`ifdef WB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // Counter is zero whenever outside REQ, so it restarts on every REQ entry.
  assign limit_hit = (state == REQ) && !wb_ack_i && (wait_q == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= ((state == REQ) && !wb_ack_i) ? wait_q + 1'b1 : '0;
      err_q  <= limit_hit;
    end
  end

  assign err_o = err_q;
`else
  assign limit_hit = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (count_i == '0) next_state = DONE;
          else               next_state = dir_i ? FETCH : REQ;
        end
      end
      FETCH: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) next_state = REQ;
      end
      REQ: begin
        // An ack in the limit cycle still completes the word.
        if (wb_ack_i)       next_state = GAP;
        else if (limit_hit) next_state = IDLE;
      end
      GAP: begin
        if (rem_q == CNT_W'(1)) next_state = DONE;
        else                    next_state = dir_q ? FETCH : REQ;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      data_q     <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && (count_i != '0)) begin
            addr_q <= base_addr_i & ~32'h3;
            rem_q  <= count_i;
            dir_q  <= dir_i;
          end
        end
        FETCH: begin
          if (wr_valid_i) data_q <= wr_data_i;
        end
        REQ: begin
          if (wb_ack_i && !dir_q) begin
            rd_data_q  <= wb_data_i;
            rd_valid_q <= 1'b1;
          end
        end
        GAP: begin
          addr_q <= addr_q + 32'd4;
          rem_q  <= rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are gated so they read zero whenever no request is open.
  assign req         = (state == REQ);
  assign wb_cyc_o    = req;
  assign wb_stb_o    = req;
  assign wb_we_o     = req & dir_q;
  assign wb_sel_o    = req ? 4'hF : 4'h0;
  assign wb_addr_o   = req ? addr_q : 32'h0;
  assign wb_data_o   = (req & dir_q) ? data_q : 32'h0;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_wb_block_master.sv
// Self-checking bench for wb_block_master with a RAM-like Wishbone slave model.
// Define WB_TIMEOUT_EN to also exercise the ack timeout abort.
module tb_wb_block_master;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dir;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             busy, done, err;
  logic [31:0]      wr_data;
  logic             wr_valid, wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             wb_cyc, wb_stb, wb_we;
  logic [31:0]      wb_addr, wb_wdata, wb_rdata;
  logic [3:0]       wb_sel;
  logic             wb_ack;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  wb_block_master #(
    .CNT_W(CNT_W)
`ifdef WB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir),
    .base_addr_i(base_addr), .count_i(count),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_addr_o(wb_addr), .wb_sel_o(wb_sel), .wb_data_o(wb_wdata),
    .wb_data_i(wb_rdata), .wb_ack_i(wb_ack), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: acks once, one cycle after the rising edge of its request.
  logic [31:0] mem [256];
  logic        prev_req;
  logic        never_ack;

  always @(posedge clk) begin
    prev_req <= wb_stb;
    wb_ack   <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5000_0000 + 32'(i);
      wb_rdata <= '0;
    end else if (wb_cyc && wb_stb && !prev_req && !never_ack) begin
      wb_ack <= 1'b1;
      if (wb_we) mem[wb_addr[9:2]] <= wb_wdata;
      else       wb_rdata <= mem[wb_addr[9:2]];
    end
  end

  // Scoreboard: {sel, we, addr, data} per expected bus word, and expected read words.
  logic [68:0] bus_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_src_q[$];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int   done_cnt = 0, err_cnt = 0, req_starts = 0, cyc_high = 0;
  int   last_ack_cyc = 0, last_rd_cyc = 0, ack_in_block = 0, rd_in_block = 0;
  logic last_ack = 1'b0, prev_cyc = 1'b0;
  logic blk_dir = 1'b0;
  int   blk_count = 0;

  always @(negedge clk) begin
    logic [68:0] e;
    logic [31:0] r;
    if (!rst) begin
      check("cyc_eq_stb", wb_stb, wb_cyc);
      if (wb_cyc) cyc_high++;
      if (wb_cyc && !prev_cyc) req_starts++;
      if (last_ack) check("cyc_gap", wb_cyc, 1'b0);
      if (wb_cyc && wb_stb && wb_ack) begin
        check("bus_avail", bus_q.size() != 0, 1'b1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          check("bus_sel", wb_sel, e[68:65]);
          check("bus_we", wb_we, e[64]);
          check("bus_addr", wb_addr, e[63:32]);
          if (e[64]) check("bus_wdata", wb_wdata, e[31:0]);
        end
        if (ack_in_block > 0) check("ack_spacing", cyc_n - last_ack_cyc, blk_dir ? 4 : 3);
        ack_in_block++;
        last_ack_cyc = cyc_n;
      end
      last_ack = wb_cyc & wb_ack;
      prev_cyc = wb_cyc;
      if (rd_valid) begin
        check("rd_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check("rd_data", rd_data, r);
        end
        if (rd_in_block > 0) check("rd_spacing", cyc_n - last_rd_cyc, 3);
        rd_in_block++;
        last_rd_cyc = cyc_n;
      end
      if (done) begin
        done_cnt++;
        check("done_rd_excl", rd_valid, 1'b0);
        if (!blk_dir && blk_count != 0) check("done_after_rd", cyc_n - last_rd_cyc, 1);
      end
      if (err) err_cnt++;
    end
  end

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_q.push_back({4'hF, we, a, d});
  endtask

  task automatic do_block(input logic d, input logic [31:0] base, input int n, input logic restart);
    int t = 0;
    blk_dir = d; blk_count = n; ack_in_block = 0; rd_in_block = 0;
    @(negedge clk);
    start = 1'b1; dir = d; base_addr = base; count = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", busy, 1'b1);
    if (n == 0) check("zero_done", done, 1'b1);
    while (t < 400) begin
      if (wr_src_q.size() > 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_src_q[0];
      end else wr_valid = 1'b0;
      if (wr_valid && wr_ready) void'(wr_src_q.pop_front());
      if (restart && t == 2) begin
        start = 1'b1; count = CNT_W'(5); dir = ~d;
      end else start = 1'b0;
      if (!busy) break;
      @(negedge clk);
      t++;
    end
    wr_valid = 1'b0;
    start = 1'b0;
    check("blk_finish", t < 400, 1'b1);
  endtask

  task automatic end_block(input string tag, input int done0, input int err0, input int dd, input int de);
    check({tag, "_done"}, done_cnt - done0, dd);
    check({tag, "_err"}, err_cnt - err0, de);
    check({tag, "_busq"}, bus_q.size(), 0);
    check({tag, "_rdq"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int d0, e0, r0, n, b;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; count = '0;
    wr_data = '0; wr_valid = 1'b0; never_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cyc", {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("rst_addr", wb_addr, 32'h0);
    check("rst_rdv", {rd_valid, wr_ready}, 2'b00);
    rst = 1'b0;

    // Write 4 words at 0x100, then read 3 back.
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      wr_src_q.push_back(32'hA0 + 32'(i));
      push_bus(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    end
    do_block(1'b1, 32'h100, 4, 1'b0);
    end_block("wr4", d0, e0, 1, 0);

    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      push_bus(1'b0, 32'h100 + 32'(4 * i), 32'h0);
      exp_q.push_back(32'hA0 + 32'(i));
    end
    do_block(1'b0, 32'h102, 3, 1'b0);
    end_block("rd3", d0, e0, 1, 0);

    // Random block written then read back.
    n = $urandom_range(2, 6);
    b = $urandom_range(128, 200);
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      wr_src_q.push_back(w);
      push_bus(1'b1, 32'(4 * (b + i)), w);
      exp_q.push_back(w);
    end
    do_block(1'b1, 32'(4 * b), n, 1'b0);
    for (int i = 0; i < n; i++) push_bus(1'b0, 32'(4 * (b + i)), 32'h0);
    do_block(1'b0, 32'(4 * b), n, 1'b0);
    end_block("rand", d0, e0, 2, 0);

    // Zero-count start: done only, no bus request.
    d0 = done_cnt; e0 = err_cnt; r0 = req_starts;
    do_block(1'b0, 32'h200, 0, 1'b0);
    end_block("zero", d0, e0, 1, 0);
    check("zero_nocyc", req_starts - r0, 0);

    // Second start while busy is ignored.
    d0 = done_cnt; e0 = err_cnt; r0 = req_starts;
    for (int i = 0; i < 2; i++) begin
      push_bus(1'b0, 32'h100 + 32'(4 * i), 32'h0);
      exp_q.push_back(32'hA0 + 32'(i));
    end
    do_block(1'b0, 32'h100, 2, 1'b1);
    repeat (4) @(negedge clk);
    end_block("restart", d0, e0, 1, 0);
    check("restart_reqs", req_starts - r0, 2);

    // Address wrap.
    d0 = done_cnt; e0 = err_cnt;
    push_bus(1'b0, 32'hFFFF_FFFC, 32'h0);
    push_bus(1'b0, 32'h0000_0000, 32'h0);
    exp_q.push_back(32'h5000_00FF);
    exp_q.push_back(32'h5000_0000);
    do_block(1'b0, 32'hFFFF_FFFC, 2, 1'b0);
    end_block("wrap", d0, e0, 1, 0);

    // Reset during the second request of a 4-word read.
    d0 = done_cnt; e0 = err_cnt; r0 = req_starts;
    blk_dir = 1'b0; blk_count = 4; ack_in_block = 0; rd_in_block = 0;
    push_bus(1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'h5000_0000);
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = 32'h0; count = CNT_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && (req_starts - r0) < 2; t++) begin
      @(negedge clk);
      #1;
    end
    check("rst_mid_req", req_starts - r0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc", {wb_cyc, wb_stb}, 2'b00);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    end_block("rstmid", d0, e0, 0, 0);

    // A 1-word read after reset completes normally.
    d0 = done_cnt; e0 = err_cnt;
    push_bus(1'b0, 32'h8, 32'h0);
    exp_q.push_back(32'h5000_0002);
    do_block(1'b0, 32'h8, 1, 1'b0);
    end_block("post_rst", d0, e0, 1, 0);

`ifdef WB_TIMEOUT_EN
    // Slave never acks: request held for the full timeout, then abort.
    d0 = done_cnt; e0 = err_cnt;
    never_ack = 1'b1;
    cyc_high = 0;
    do_block(1'b0, 32'h40, 3, 1'b0);
    repeat (3) @(negedge clk);
    check("to_cyc_len", cyc_high, 8);
    end_block("timeout", d0, e0, 0, 1);
    never_ack = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_block_master.md
Name: wb_block_master

Overview:
Wishbone initiator that moves a block of 32-bit words between a local streaming interface and any Wishbone slave, e.g. the on-chip RAM slave. It is the master-side counterpart of the on-chip RAM slave. It is used by test/boot logic to preload or dump RAM without the CPU. It issues single-word classic cycles and drops cyc/stb between words, because that slave acknowledges only on the rising edge of its request.

Parameters:
CNT_W, 16, width of word-count input/remaining counter
TIMEOUT_CYCLES, 256, max cycles waiting for ack before abort (only with WB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse; sampled only in IDLE
dir_i  in  1  0 = read from bus, 1 = write to bus; latched at start
base_addr_i  in  32  byte address of first word; bits [1:0] forced to 0
count_i  in  CNT_W  number of words; latched at start
busy_o  out  1  high from accepted start until return to IDLE
done_o  out  1  1-cycle pulse: block complete
err_o  out  1  1-cycle pulse: ack timeout abort
wr_data_i  in  32  write word from local source
wr_valid_i  in  1  write word valid
wr_ready_o  out  1  block can take a write word (FETCH state)
rd_data_o  out  32  read word to local sink
rd_valid_o  out  1  1-cycle pulse, rd_data_o valid; no backpressure
wb_cyc_o, wb_stb_o  out  1 each  bus request, always driven equal
wb_we_o  out  1  write enable
wb_addr_o  out  32  word-aligned byte address
wb_sel_o  out  4  byte enables, always 4'hF during a request
wb_data_o  out  32  write data
wb_data_i  in  32  read data, sampled in ack cycle
wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-block abandons the transfer at the next edge: cyc/stb low, no done_o, no err_o.
- States: IDLE, FETCH, REQ, GAP, DONE.
- IDLE: outputs low.
  - start_i with count_i != 0: latch addr (base_addr_i & ~3), remaining = count_i, and dir; busy_o = 1. Go to FETCH if write, REQ if read.
  - start_i with count_i == 0: go to DONE; no bus activity.
- FETCH: wr_ready_o = 1. On wr_valid_i & wr_ready_o, latch wr_data_i into wb_data_o and go to REQ. Waits indefinitely.
- REQ: cyc = stb = 1; we = dir; sel = F; addr and data held stable. On wb_ack_i:
  - Read: rd_data_o <= wb_data_i and rd_valid_o pulses next cycle.
  - In both directions, go to GAP.
- GAP: cyc/stb = 0 for exactly one cycle; addr += 4 (wraps mod 2^32); remaining -= 1. If remaining was 1, go to DONE; else go to FETCH (write) or REQ (read).
- DONE: done_o = 1 for one cycle; busy_o drops the following cycle; go to IDLE.
- Latency with an ack that arrives 1 cycle after stb rises:
  - Read: 3 cycles/word (REQ 2 + GAP 1).
  - Write: 4 cycles/word with wr_valid_i held high.
- Ignored inputs: start_i while busy; wb_ack_i outside REQ.
- rd_valid_o and done_o never coincide. The last rd_valid_o occurs in the GAP cycle; done_o follows 1 cycle later.
- Counter: remaining is CNT_W bits. Max block is 2^CNT_W - 1 words.

Optional Feature:
WB_TIMEOUT_EN:
- Defined: a wait counter is cleared on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES-1 without ack:
  - next cycle: cyc/stb = 0, err_o pulses 1 cycle, state returns to IDLE, busy_o = 0;
  - no done_o, remaining words discarded.
  - An ack in the same cycle as the limit wins: normal completion.
- Undefined: REQ waits forever for ack; err_o tied 0; no counter logic.

Test Plan:
- Write 4 words, base 0x100, data 0xA0..0xA3, slave acks 1 cycle after stb:
  - bus writes addr 0x100/104/108/10C in order with those data, sel F;
  - cyc low ≥1 cycle between words; single done_o after last ack.
- Read 3 words, base 0x100, after above: rd_valid_o pulses 3 times with 0xA0, 0xA1, 0xA2; 3 cycles apart; done_o 1 cycle after last rd_valid_o.
- start_i with count_i = 0: done_o pulses 1 cycle later; cyc never asserted. A second start_i while busy during a 2-word read is ignored.
- Address wrap, base 0xFFFFFFFC, read 2 words: addresses 0xFFFFFFFC then 0x00000000.
- Reset during REQ of word 2 of 4: cyc/stb low the cycle after rst_i; no done_o. A new 1-word read after reset completes normally.
- With WB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks: cyc/stb held exactly 8 cycles, then dropped; err_o 1-cycle pulse; no done_o; busy_o = 0.
